// File: rtl/sincos_pkg.sv
// Shared definitions for the sin/cos operand front-end: FSM states,
// IEEE-754 constants, function select encoding and field accessors.
package sincos_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    BUSY  = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;
  localparam logic [31:0] FP_ONE  = 32'h3F80_0000;

  localparam logic SEL_SIN = 1'b0;
  localparam logic SEL_COS = 1'b1;

  localparam int EXP_MSB  = 30;
  localparam int EXP_LSB  = 23;
  localparam int FRAC_MSB = 22;
  localparam int FRAC_LSB = 0;

  function automatic logic [7:0] fp_exp(input logic [31:0] x);
    return x[EXP_MSB:EXP_LSB];
  endfunction

  function automatic logic [22:0] fp_frac(input logic [31:0] x);
    return x[FRAC_MSB:FRAC_LSB];
  endfunction

endpackage

// File: rtl/sincos_ctrl_classify.sv
// Combinational special-case classifier for a single-precision operand:
// flags Inf, NaN (quiet or signaling) and signed zero.
module sincos_ctrl_classify
  import sincos_pkg::*;
(
  input  logic [31:0] op_i,
  output logic        is_inf_o,
  output logic        is_nan_o,
  output logic        is_zero_o
);

  logic expOnes;
  logic fracZero;

  assign expOnes   = (fp_exp(op_i) == 8'hFF);
  assign fracZero  = (fp_frac(op_i) == 23'd0);

  assign is_inf_o  = expOnes && fracZero;
  assign is_nan_o  = expOnes && !fracZero;
  assign is_zero_o = (op_i[30:0] == 31'd0);

endmodule

// File: rtl/sincos_ctrl.sv
// Sin/cos sequencer: captures one operand, answers special cases directly,
// otherwise launches the iterative core and waits with a timeout.
module sincos_ctrl
  import sincos_pkg::*;
#(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_sel,
  output logic        core_start,
  output logic [31:0] core_arg,
  output logic        core_sel,
  input  logic        core_done,
  input  logic [31:0] core_result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_invalid,
  output logic        out_timeout
);

  localparam int CW = $clog2(TIMEOUT_CYC);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

  state_e        state_q, state_d;
  logic [31:0]   arg_q, arg_d;
  logic          sel_q, sel_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          coreStart_q, coreStart_d;
  logic [31:0]   outData_q, outData_d;
  logic          outInvalid_q, outInvalid_d;
  logic          outTimeout_q, outTimeout_d;
  logic          inReady_q;
  logic          outValid_q;

  logic isInf, isNan, isZero, isDenorm;

  sincos_ctrl_classify u_classify (
    .op_i      (arg_q),
    .is_inf_o  (isInf),
    .is_nan_o  (isNan),
    .is_zero_o (isZero)
  );

  assign isDenorm = (fp_exp(arg_q) == 8'd0) && (fp_frac(arg_q) != 23'd0);

  always_comb begin
    state_d      = state_q;
    arg_d        = arg_q;
    sel_d        = sel_q;
    cnt_d        = cnt_q;
    coreStart_d  = 1'b0;
    outData_d    = outData_q;
    outInvalid_d = outInvalid_q;
    outTimeout_d = outTimeout_q;
    case (state_q)
      IDLE: begin
        if (in_valid && inReady_q) begin
          arg_d   = in_data;
          sel_d   = in_sel;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (isNan || isInf) begin
          outData_d    = FP_QNAN;
          outInvalid_d = 1'b1;
          outTimeout_d = 1'b0;
          state_d      = DONE;
        end else if (isZero || isDenorm) begin
          // sin(x) ~ x for tiny x keeps the sign of zero; cos is exactly one
          outData_d    = (sel_q == SEL_COS) ? FP_ONE : arg_q;
          outInvalid_d = 1'b0;
          outTimeout_d = 1'b0;
          state_d      = DONE;
        end else begin
          cnt_d       = '0;
          coreStart_d = 1'b1;
          state_d     = BUSY;
        end
      end
      BUSY: begin
        if (core_done) begin
          outData_d    = core_result;
          outInvalid_d = 1'b0;
          outTimeout_d = 1'b0;
          state_d      = DONE;
        end else if (cnt_q == CNT_LAST) begin
          outData_d    = FP_QNAN;
          outInvalid_d = 1'b0;
          outTimeout_d = 1'b1;
          state_d      = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      arg_q        <= '0;
      sel_q        <= 1'b0;
      cnt_q        <= '0;
      coreStart_q  <= 1'b0;
      outData_q    <= '0;
      outInvalid_q <= 1'b0;
      outTimeout_q <= 1'b0;
      inReady_q    <= 1'b1;
      outValid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      arg_q        <= arg_d;
      sel_q        <= sel_d;
      cnt_q        <= cnt_d;
      coreStart_q  <= coreStart_d;
      outData_q    <= outData_d;
      outInvalid_q <= outInvalid_d;
      outTimeout_q <= outTimeout_d;
      inReady_q    <= (state_d == IDLE);
      outValid_q   <= (state_d == DONE);
    end
  end

  assign in_ready    = inReady_q;
  assign core_start  = coreStart_q;
  assign core_arg    = arg_q;
  assign core_sel    = sel_q;
  assign out_valid   = outValid_q;
  assign out_data    = outData_q;
  assign out_invalid = outInvalid_q;
  assign out_timeout = outTimeout_q;

endmodule

// File: tb/tb_sincos_ctrl.sv
// Self-checking bench for sincos_ctrl: scoreboard of expected results,
// one task per scenario, exact cycle timing against the accept edge.
module tb_sincos_ctrl;
  import sincos_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_sel;
  logic        core_start;
  logic [31:0] core_arg;
  logic        core_sel;
  logic        core_done;
  logic [31:0] core_result;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_invalid;
  logic        out_timeout;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] data;
    logic        inv;
    logic        tmo;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  sincos_ctrl #(.TIMEOUT_CYC(64)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_sel      (in_sel),
    .core_start  (core_start),
    .core_arg    (core_arg),
    .core_sel    (core_sel),
    .core_done   (core_done),
    .core_result (core_result),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_invalid (out_invalid),
    .out_timeout (out_timeout)
  );

  function automatic exp_t mk(input logic [31:0] d, input logic i, input logic t);
    exp_t e;
    e.data = d;
    e.inv  = i;
    e.tmo  = t;
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Returns just after the accept edge, i.e. in the CHECK cycle.
  task automatic send_op(input logic [31:0] d, input logic s);
    int n = 0;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL send_op_ready got in_ready=%b want 1", in_ready);
    end
    in_valid = 1'b1;
    in_data  = d;
    in_sel   = s;
    step();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_sel = 1'b0;
    out_ready = 1'b1; core_done = 1'b0; core_result = '0;
    step();
    step();
    checks++;
    if ({in_ready, out_valid, out_invalid, out_timeout, core_start, core_sel} !== 6'b100000) begin
      errors++;
      $display("[TB] FAIL reset_ctrl got %b want 100000",
               {in_ready, out_valid, out_invalid, out_timeout, core_start, core_sel});
    end
    checks++;
    if (out_data !== 32'h0 || core_arg !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_data got out_data=%h core_arg=%h want 0/0", out_data, core_arg);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_normal();
    exp_t e;
    sb.push_back(mk(32'h3EF5_7744, 1'b0, 1'b0));
    send_op(32'h3F00_0000, SEL_SIN);
    step();
    checks++;
    if (core_start !== 1'b1 || core_arg !== 32'h3F00_0000 || core_sel !== SEL_SIN) begin
      errors++;
      $display("[TB] FAIL normal_start got start=%b arg=%h sel=%b want 1/3f000000/0",
               core_start, core_arg, core_sel);
    end
    step();
    checks++;
    if (core_start !== 1'b0) begin
      errors++;
      $display("[TB] FAIL normal_pulse got core_start=%b want 0", core_start);
    end
    repeat (9) step();
    core_done = 1'b1; core_result = 32'h3EF5_7744;
    step();
    core_done = 1'b0; core_result = '0;
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL normal_latency got out_valid=%b want 1", out_valid);
    end
    e = sb.pop_front();
    checks++;
    if ({out_data, out_invalid, out_timeout} !== {e.data, e.inv, e.tmo}) begin
      errors++;
      $display("[TB] FAIL normal_result got %h/%b/%b want %h/%b/%b",
               out_data, out_invalid, out_timeout, e.data, e.inv, e.tmo);
    end
    step();
  endtask

  task automatic test_special();
    logic [31:0] ops[4] = '{32'h7F80_0000, 32'hFF80_0001, 32'h7F80_0001, 32'hFFC0_1234};
    logic        sels[4] = '{SEL_COS, SEL_SIN, SEL_SIN, SEL_COS};
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      sb.push_back(mk(32'h7FC0_0000, 1'b1, 1'b0));
      send_op(ops[i], sels[i]);
      step();
      checks++;
      if (out_valid !== 1'b1 || core_start !== 1'b0) begin
        errors++;
        $display("[TB] FAIL special_timing[%0d] got valid=%b start=%b want 1/0", i, out_valid, core_start);
      end
      e = sb.pop_front();
      checks++;
      if ({out_data, out_invalid, out_timeout} !== {e.data, e.inv, e.tmo}) begin
        errors++;
        $display("[TB] FAIL special_result[%0d] got %h/%b/%b want %h/%b/%b",
                 i, out_data, out_invalid, out_timeout, e.data, e.inv, e.tmo);
      end
      step();
    end
  endtask

  task automatic test_zero_denorm();
    logic [31:0] ops[6]  = '{32'h8000_0000, 32'h8000_0000, 32'h0000_0001,
                             32'h0000_0001, 32'h0000_0000, 32'h807F_FFFF};
    logic        sels[6] = '{SEL_SIN, SEL_COS, SEL_SIN, SEL_COS, SEL_SIN, SEL_SIN};
    logic [31:0] want[6] = '{32'h8000_0000, 32'h3F80_0000, 32'h0000_0001,
                             32'h3F80_0000, 32'h0000_0000, 32'h807F_FFFF};
    exp_t e;
    for (int i = 0; i < 6; i++) begin
      sb.push_back(mk(want[i], 1'b0, 1'b0));
      send_op(ops[i], sels[i]);
      step();
      checks++;
      if (out_valid !== 1'b1 || core_start !== 1'b0) begin
        errors++;
        $display("[TB] FAIL zero_timing[%0d] got valid=%b start=%b want 1/0", i, out_valid, core_start);
      end
      e = sb.pop_front();
      checks++;
      if ({out_data, out_invalid, out_timeout} !== {e.data, e.inv, e.tmo}) begin
        errors++;
        $display("[TB] FAIL zero_result[%0d] got %h/%b/%b want %h/%b/%b",
                 i, out_data, out_invalid, out_timeout, e.data, e.inv, e.tmo);
      end
      step();
    end
  endtask

  task automatic test_timeout();
    exp_t e;
    sb.push_back(mk(32'h7FC0_0000, 1'b0, 1'b1));
    send_op(32'h3F80_0000, SEL_COS);
    step();
    checks++;
    if (core_start !== 1'b1 || core_sel !== SEL_COS) begin
      errors++;
      $display("[TB] FAIL timeout_start got start=%b sel=%b want 1/1", core_start, core_sel);
    end
    repeat (63) step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL timeout_early got out_valid=%b want 0 at S+63", out_valid);
    end
    step();
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL timeout_edge got out_valid=%b want 1 at S+64", out_valid);
    end
    e = sb.pop_front();
    checks++;
    if ({out_data, out_invalid, out_timeout} !== {e.data, e.inv, e.tmo}) begin
      errors++;
      $display("[TB] FAIL timeout_result got %h/%b/%b want %h/%b/%b",
               out_data, out_invalid, out_timeout, e.data, e.inv, e.tmo);
    end
    step();

    sb.push_back(mk(32'h1234_5678, 1'b0, 1'b0));
    send_op(32'h4049_0FDB, SEL_SIN);
    step();
    repeat (63) step();
    core_done = 1'b1; core_result = 32'h1234_5678;
    step();
    core_done = 1'b0; core_result = '0;
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL race_valid got out_valid=%b want 1", out_valid);
    end
    e = sb.pop_front();
    checks++;
    if ({out_data, out_invalid, out_timeout} !== {e.data, e.inv, e.tmo}) begin
      errors++;
      $display("[TB] FAIL race_result got %h/%b/%b want %h/%b/%b",
               out_data, out_invalid, out_timeout, e.data, e.inv, e.tmo);
    end
    step();
  endtask

  task automatic test_backpressure();
    exp_t e;
    out_ready = 1'b0;
    sb.push_back(mk(32'h3F80_0000, 1'b0, 1'b0));
    send_op(32'h0000_0001, SEL_COS);
    step();
    e = sb.pop_front();
    checks++;
    if (out_valid !== 1'b1 || {out_data, out_invalid, out_timeout} !== {e.data, e.inv, e.tmo}) begin
      errors++;
      $display("[TB] FAIL bp_first got valid=%b %h/%b/%b want 1 %h/%b/%b",
               out_valid, out_data, out_invalid, out_timeout, e.data, e.inv, e.tmo);
    end
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin
        core_done = 1'b1; core_result = 32'hDEAD_BEEF;
      end
      step();
      core_done = 1'b0; core_result = '0;
      checks++;
      if ({out_valid, in_ready, out_data, out_invalid, out_timeout} !==
          {1'b1, 1'b0, e.data, e.inv, e.tmo}) begin
        errors++;
        $display("[TB] FAIL bp_hold[%0d] got valid=%b rdy=%b %h/%b/%b want 1 0 %h/%b/%b",
                 i, out_valid, in_ready, out_data, out_invalid, out_timeout, e.data, e.inv, e.tmo);
      end
    end
    out_ready = 1'b1;
    step();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bp_release got rdy=%b valid=%b want 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_busy();
    send_op(32'h3F00_0000, SEL_SIN);
    step();
    checks++;
    if (core_start !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rb_start got core_start=%b want 1", core_start);
    end
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || core_start !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rb_idle got rdy=%b valid=%b start=%b want 1/0/0", in_ready, out_valid, core_start);
    end
    step();
    step();
    core_done = 1'b1; core_result = 32'h1111_1111;
    step();
    core_done = 1'b0; core_result = '0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (out_valid !== 1'b0 || core_start !== 1'b0 || in_ready !== 1'b1) begin
        errors++;
        $display("[TB] FAIL rb_quiet[%0d] got valid=%b start=%b rdy=%b want 0/0/1",
                 i, out_valid, core_start, in_ready);
      end
      step();
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL sb_empty got %0d entries want 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_special();
    test_zero_denorm();
    test_timeout();
    test_backpressure();
    test_reset_busy();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
